mips_loader: RTL and testbench

- Upstream feeder of the `mips` pipeline.
- Receives a program as a byte stream over a valid/ready handshake and packs it big-endian into 32-bit instructions.
- Writes each instruction into the instruction memory, holding the CPU in reset meanwhile; a HALT word ends the load, then the CPU is released.
- Sits between the host link (UART or bench driver) and the IF-stage instruction memory.

---
 rtl/mips_loader_pkg.sv | 24 ++
 rtl/loader_word_packer.sv | 48 ++++
 rtl/mips_loader.sv | 144 ++++++++++++++
 tb/tb_mips_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_loader_pkg.sv
// ---------------------------------------------------------------------------
// mips_loader_pkg: shared constants for the program loader and its packer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_loader_pkg;

  localparam int          DATA_WIDTH       = 32;
  localparam logic [31:0] LOADER_HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [2:0] LD_IDLE  = 3'd0;
  localparam logic [2:0] LD_RECV  = 3'd1;
  localparam logic [2:0] LD_WRITE = 3'd2;
  localparam logic [2:0] LD_DONE  = 3'd3;
  localparam logic [2:0] LD_ERROR = 3'd4;

  function automatic logic [DATA_WIDTH-1:0] word_addr(input logic [31:0] idx);
    return DATA_WIDTH'(idx) << 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/loader_word_packer.sv
// ---------------------------------------------------------------------------
// loader_word_packer: collects four bytes big-endian into one 32-bit word.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module loader_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] shift_q, shift_d;

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clr_i) begin
      idx_d   = 2'd0;
      shift_d = 24'd0;
    end else if (shift_i) begin
      idx_d   = idx_q + 2'd1;
      shift_d = {shift_q[15:0], byte_i};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // The fourth byte is merged combinationally so the write can issue on its accept edge.
  assign word_o       = {shift_q, byte_i};
  assign word_ready_o = shift_i & (idx_q == 2'd3);

endmodule

`default_nettype wire

// File: rtl/mips_loader.sv
// ---------------------------------------------------------------------------
// mips_loader: loads a byte-streamed program into IMEM, holding the CPU in reset.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mips_loader
  import mips_loader_pkg::*;
#(
  parameter int                    IMEM_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = LOADER_HALT_WORD,
  parameter int                    CNT_W      = $clog2(IMEM_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  output logic                  o_imem_we,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  output logic [DATA_WIDTH-1:0] o_imem_wdata,
  output logic                  o_cpu_reset,
  output logic                  o_done,
  output logic                  o_error,
  output logic [CNT_W-1:0]      o_word_count
);

  logic [2:0]            state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  accept;
  logic                  start_ok;
  logic                  word_ready;
  logic [31:0]           pk_word;

  assign accept = ready_q & i_byte_valid;

  loader_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (start_ok),
    .shift_i      (accept),
    .byte_i       (i_byte),
    .word_o       (pk_word),
    .word_ready_o (word_ready)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;
    count_d     = count_q;
    start_ok    = 1'b0;
    case (state_q)
      LD_IDLE, LD_DONE, LD_ERROR: begin
        if (i_start) begin
          start_ok    = 1'b1;
          state_d     = LD_RECV;
          count_d     = '0;
          addr_d      = '0;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
        end
      end
      LD_RECV: begin
        if (word_ready) begin
          state_d = LD_WRITE;
          // A full memory suppresses the strobe; WRITE then sees we_q low and errors out.
          if (count_q != CNT_W'(IMEM_DEPTH)) begin
            we_d    = 1'b1;
            addr_d  = word_addr(32'(count_q));
            wdata_d = pk_word;
          end
        end
      end
      LD_WRITE: begin
        if (!we_q) begin
          state_d = LD_ERROR;
          error_d = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
          if (wdata_q == HALT_WORD) begin
            state_d     = LD_DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = LD_RECV;
          end
        end
      end
      default: state_d = LD_IDLE;
    endcase
    ready_d = (state_d == LD_RECV);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LD_IDLE;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
      count_q     <= count_d;
    end
  end

  assign o_byte_ready = ready_q;
  assign o_imem_we    = we_q;
  assign o_imem_addr  = addr_q;
  assign o_imem_wdata = wdata_q;
  assign o_cpu_reset  = cpu_reset_q;
  assign o_done       = done_q;
  assign o_error      = error_q;
  assign o_word_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_loader.sv
// ---------------------------------------------------------------------------
// tb_mips_loader: randomized self-checking bench for mips_loader.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mips_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  typedef struct {
    int          dut;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start [2];
  logic [7:0]  byt   [2];
  logic        valid [2];
  logic        ready [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        cpur  [2];
  logic        done  [2];
  logic        err   [2];
  logic [6:0]  cnt0;
  logic [2:0]  cnt1;
  logic [31:0] cnt_v [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ready_drops = 0;
  wr_t wq[$];

  always #5 clk = ~clk;

  assign cnt_v[0] = {25'd0, cnt0};
  assign cnt_v[1] = {29'd0, cnt1};

  mips_loader #(.IMEM_DEPTH(64)) u_dut0 (
    .clk(clk), .reset(reset), .i_start(start[0]), .i_byte(byt[0]),
    .i_byte_valid(valid[0]), .o_byte_ready(ready[0]), .o_imem_we(we[0]),
    .o_imem_addr(addr[0]), .o_imem_wdata(wdata[0]), .o_cpu_reset(cpur[0]),
    .o_done(done[0]), .o_error(err[0]), .o_word_count(cnt0)
  );

  mips_loader #(.IMEM_DEPTH(4)) u_dut1 (
    .clk(clk), .reset(reset), .i_start(start[1]), .i_byte(byt[1]),
    .i_byte_valid(valid[1]), .o_byte_ready(ready[1]), .o_imem_we(we[1]),
    .o_imem_addr(addr[1]), .o_imem_wdata(wdata[1]), .o_cpu_reset(cpur[1]),
    .o_done(done[1]), .o_error(err[1]), .o_word_count(cnt1)
  );

  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++)
      if (reset && we[d]) wq.push_back('{d, addr[d], wdata[d], cyc});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_start(input int d);
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    @(negedge clk);
    check_eq("start_cpu_reset", {31'd0, cpur[d]}, 1);
    check_eq("start_done_clr", {31'd0, done[d]}, 0);
    check_eq("start_err_clr", {31'd0, err[d]}, 0);
    check_eq("start_count", cnt_v[d], 0);
    check_eq("start_ready", {31'd0, ready[d]}, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input bit mid, input int gap);
    bit acc = 1'b0;
    byt[d]   = b;
    valid[d] = 1'b1;
    for (int t = 0; t < 40 && !acc; t++) begin
      @(negedge clk);
      acc = ready[d];
      if (mid && !ready[d]) ready_drops++;
      @(posedge clk); #1;
    end
    valid[d] = 1'b0;
    check_eq("byte_accept", {31'd0, acc}, 1);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  // gap < 0 selects a random idle gap of 0..3 cycles after every byte.
  task automatic run_load(input int d, input logic [31:0] words[$], input int gap, input int depth);
    wr_t exp_q[$];
    int  nsend = 0;
    bit  exp_done = 1'b0;
    bit  exp_err  = 1'b0;
    int  nw;
    for (int k = 0; k < words.size(); k++) begin
      nsend = k + 1;
      if (k == depth) begin exp_err = 1'b1; break; end
      exp_q.push_back('{d, 32'(k * 4), words[k], 0});
      if (words[k] == HALT) begin exp_done = 1'b1; break; end
    end
    ready_drops = 0;
    wq.delete();
    do_start(d);
    for (int k = 0; k < nsend; k++)
      for (int b = 0; b < 4; b++)
        send_byte(d, words[k][31 - 8 * b -: 8], b != 0,
                  (gap < 0) ? int'($urandom_range(0, 3)) : gap);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (done[d] || err[d]) break;
    end
    check_eq("n_writes", wq.size(), exp_q.size());
    nw = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
    for (int i = 0; i < nw; i++) begin
      check_eq("wr_dut", wq[i].dut, exp_q[i].dut);
      check_eq("wr_addr", wq[i].addr, exp_q[i].addr);
      check_eq("wr_data", wq[i].data, exp_q[i].data);
      if (gap == 0 && i > 0) check_eq("wr_spacing", wq[i].cyc - wq[i-1].cyc, 5);
    end
    check_eq("done", {31'd0, done[d]}, {31'd0, exp_done});
    check_eq("error", {31'd0, err[d]}, {31'd0, exp_err});
    check_eq("cpu_reset", {31'd0, cpur[d]}, {31'd0, !exp_done});
    check_eq("word_count", cnt_v[d], exp_err ? depth : exp_q.size());
    check_eq("ready_after", {31'd0, ready[d]}, 0);
    check_eq("ready_in_recv", ready_drops, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prog[$];
    logic [31:0] w[$];
    int n, depth, d, halt_end;
    logic [31:0] r;

    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; byt[i] = 8'h00; valid[i] = 1'b0;
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cpu_reset", {31'd0, cpur[0]}, 1);
    check_eq("rst_ready", {31'd0, ready[0]}, 0);
    check_eq("rst_we", {31'd0, we[0]}, 0);
    check_eq("rst_done", {31'd0, done[0]}, 0);
    check_eq("rst_error", {31'd0, err[0]}, 0);
    check_eq("rst_addr", addr[0], 0);
    check_eq("rst_wdata", wdata[0], 0);
    check_eq("rst_count", cnt_v[0], 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic full-rate load, then a throttled reload from DONE.
    prog = '{32'h2001_0005, 32'h2002_000A, HALT};
    run_load(0, prog, 0, 64);
    run_load(0, prog, 2, 64);

    // Reset mid-word: partial word discarded, outputs reset asynchronously.
    wq.delete();
    do_start(0);
    send_byte(0, 8'h20, 1'b0, 0);
    send_byte(0, 8'h01, 1'b1, 0);
    #2 reset = 1'b0;
    #1;
    check_eq("midrst_cpu_reset", {31'd0, cpur[0]}, 1);
    check_eq("midrst_ready", {31'd0, ready[0]}, 0);
    check_eq("midrst_we", {31'd0, we[0]}, 0);
    check_eq("midrst_count", cnt_v[0], 0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_no_write", wq.size(), 0);
    prog = '{HALT};
    run_load(0, prog, 0, 64);

    // Overflow on the 4-word instance.
    prog = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'h5555_0005};
    run_load(1, prog, 0, 4);

    for (int it = 0; it < 10; it++) begin
      d        = it % 2;
      depth    = (d == 0) ? 64 : 4;
      n        = int'($urandom_range(1, 6));
      halt_end = (d == 0) ? 1 : int'($urandom_range(0, 1));
      if (!halt_end && n < 5) n = 5;
      w.delete();
      for (int k = 0; k < n; k++) begin
        r = $urandom;
        if (r == HALT) r = 32'h0;
        w.push_back(r);
      end
      if (halt_end) w[n-1] = HALT;
      run_load(d, w, (it < 4) ? 0 : -1, depth);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
